joy2quad_multi: RTL and testbench
=================================

Name: joy2quad_multi

Overview:
- Parametrised successor to the single-channel digital-to-quadrature steering encoder.
- Converts NUM_CH pairs of digital left/right controls (keyboard or joystick) into 2-bit Gray quadrature steering signals for arcade cores that expect an optical steering wheel.
- Adds per-channel acceleration: step rate ramps up while a direction is held.
- Sits between the input mapping logic and the core's SteerA/SteerB inputs, in the clk_sys domain.

Parameters:
- NUM_CH, 2, number of independent steering channels (1..4).
- DIV_W, 16, width of the divider counter and reload values.
- SLOW_DIV, 22500, initial step interval in clk_sys cycles (>= FAST_DIV, >= 2).
- FAST_DIV, 5625, minimum step interval in cycles (>= 1).
- DIV_DEC, 2800, amount subtracted from the interval at each ramp point.
- RAMP_STEPS, 8, quadrature steps taken at one interval before the next speed-up (>= 1).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- left  in  NUM_CH  per-channel turn-left request, active high, synchronous to clk_sys.
- right  in  NUM_CH  per-channel turn-right request, active high.
- accel_en  in  1  1 = acceleration ramp enabled; 0 = fixed SLOW_DIV rate.
- steer  out  2*NUM_CH  quadrature per channel; steer[2c+1] = A, steer[2c] = B.
- moving  out  NUM_CH  1 while the channel is in a stepping state.

Behaviour:
- Reset state, per channel: phase = 0, steer = 00, moving = 0, state = IDLE, div_cnt = 0, cur_div = SLOW_DIV, ramp_cnt = 0.
- Reset takes priority over all inputs and aborts any run immediately.
- Per-channel FSM states are IDLE, CW and CCW. The request in a given cycle is:
  - right & ~left: CW.
  - left & ~right: CCW.
  - both pressed, or neither: IDLE.
- Entering CW or CCW from any other state (including a direct reversal CW<->CCW):
  - cur_div <= SLOW_DIV, ramp_cnt <= 0, div_cnt <= SLOW_DIV-1.
  - No step is taken in the entry cycle.
- While in the same active state:
  - If div_cnt != 0: div_cnt decrements.
  - If div_cnt == 0: take one step and reload div_cnt <= next interval - 1.
  - The first step therefore occurs SLOW_DIV cycles after the entry cycle, and subsequent steps follow at cur_div intervals.
- Step: CW does phase+1, CCW does phase-1. The 2-bit phase wraps modulo 4 in both directions.
- Gray mapping of phase to steer {A,B}: 0 -> 00, 1 -> 01, 2 -> 11, 3 -> 10.
- steer is registered and changes on the clock edge of the step cycle. Exactly one bit of steer toggles per step.
- Ramp, applied when accel_en = 1:
  - On each step, if ramp_cnt == RAMP_STEPS-1, then ramp_cnt <= 0 and cur_div <= max(FAST_DIV, cur_div - DIV_DEC). The subtraction is computed DIV_W+1 bits wide to avoid underflow. The new cur_div applies to the reload in that same step.
  - Otherwise ramp_cnt increments.
  - When accel_en = 0: cur_div holds SLOW_DIV and ramp_cnt is ignored.
  - If accel_en falls mid-run, cur_div returns to SLOW_DIV at the next reload.
- Entering IDLE:
  - phase and steer hold their last value; moving = 0.
  - div_cnt, ramp_cnt and cur_div reset as above.
- moving is registered: 1 in every cycle after an entry into CW or CCW, 0 after an entry into IDLE.
- Channels are fully independent; there are no shared counters.

Optional Feature:
- Macro: JOY2QUAD_POS_EN.
- Defined:
  - Adds output pos [8*NUM_CH-1:0], one signed 8-bit position per channel.
  - pos is +1 per CW step and -1 per CCW step, saturating at +127/-128. Steer phase keeps wrapping after saturation.
  - Reset value is 0. pos updates in the same cycle as steer.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Bench parameters for all scenarios: NUM_CH=2, SLOW_DIV=8, FAST_DIV=2, DIV_DEC=2, RAMP_STEPS=2.
- Reset: hold reset 3 cycles with right=11 -> steer=0000, moving=00 throughout. Right held after release -> first ch0 step 8 cycles after the entry cycle.
- Fixed rate: accel_en=0, right[0]=1 for 40 cycles -> ch0 steer 00,01,11,10,00 with 8-cycle spacing; ch1 stays 00.
- Ramp: accel_en=1, right[0] held -> step intervals 8,8,6,6,4,4,2,2,2 (clamped at FAST_DIV). Exactly one steer bit toggles per step.
- Both pressed / release: left=right=1 for 20 cycles -> no steps, moving=0, phase held. Then left[0]=1 -> phase decrements (e.g. 01 -> 00 -> 10) with interval restarted at 8.
- Reversal and reset mid-run: right[0] held into the 4-cycle interval, then left[0] directly -> next step is CCW 8 cycles later. Reset asserted between steps -> steer=00 in the next cycle. With JOY2QUAD_POS_EN defined: 130 CW steps -> pos=127, and phase continues wrapping.

Source files
------------

// File: rtl/joy2quad_multi.sv
// Multi-channel left/right to Gray quadrature steering encoder with per-channel rate ramp.
// Optional JOY2QUAD_POS_EN adds a saturating signed 8-bit position output per channel.
//
// state    | meaning
// ST_IDLE  | no request or both pressed; phase held, counters parked
// ST_CW    | right held; phase steps +1 every cur_div cycles
// ST_CCW   | left held; phase steps -1 every cur_div cycles
module joy2quad_multi #(
    parameter int NUM_CH     = 2,
    parameter int DIV_W      = 16,
    parameter int SLOW_DIV   = 22500,
    parameter int FAST_DIV   = 5625,
    parameter int DIV_DEC    = 2800,
    parameter int RAMP_STEPS = 8
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     left,
    input  logic [NUM_CH-1:0]     right,
    input  logic                  accel_en,
    output logic [2*NUM_CH-1:0]   steer,
    output logic [NUM_CH-1:0]     moving
`ifdef JOY2QUAD_POS_EN
    ,
    output logic [8*NUM_CH-1:0]   pos
`endif
);

    localparam int RW = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;
    localparam logic [DIV_W-1:0] SLOW_V    = DIV_W'(SLOW_DIV);
    localparam logic [DIV_W-1:0] FAST_V    = DIV_W'(FAST_DIV);
    localparam logic [DIV_W:0]   DEC_V     = (DIV_W+1)'(DIV_DEC);
    localparam logic [RW-1:0]    RAMP_LAST = RW'(RAMP_STEPS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CW, ST_CCW} state_t;

    function automatic logic [1:0] gray(input logic [1:0] p);
        case (p)
            2'd0:    gray = 2'b00;
            2'd1:    gray = 2'b01;
            2'd2:    gray = 2'b11;
            default: gray = 2'b10;
        endcase
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t           state, state_nx, req;
        logic [1:0]       phase, phase_nx, steer_q;
        logic [DIV_W-1:0] div_cnt, div_cnt_nx, cur_div, cur_div_nx, ramped;
        logic [DIV_W:0]   dec_diff;
        logic [RW-1:0]    ramp_cnt, ramp_cnt_nx;
        logic             moving_q;
`ifdef JOY2QUAD_POS_EN
        logic             step;
        logic signed [7:0] pos_q;
`endif

        always_comb begin
            req         = ST_IDLE;
            state_nx    = state;
            phase_nx    = phase;
            div_cnt_nx  = div_cnt;
            cur_div_nx  = cur_div;
            ramp_cnt_nx = ramp_cnt;
`ifdef JOY2QUAD_POS_EN
            step        = 1'b0;
`endif
            // Wide subtraction: an underflow shows up in the extra top bit.
            dec_diff = {1'b0, cur_div} - DEC_V;
            ramped   = (dec_diff[DIV_W] || (dec_diff[DIV_W-1:0] < FAST_V)) ? FAST_V : dec_diff[DIV_W-1:0];

            if (right[c] && !left[c]) begin
                req = ST_CW;
            end else if (left[c] && !right[c]) begin
                req = ST_CCW;
            end

            state_nx = req;
            if (req != state) begin
                cur_div_nx  = SLOW_V;
                ramp_cnt_nx = '0;
                div_cnt_nx  = (req == ST_IDLE) ? '0 : SLOW_V - DIV_W'(1);
            end else if (req != ST_IDLE) begin
                if (div_cnt != '0) begin
                    div_cnt_nx = div_cnt - DIV_W'(1);
                end else begin
`ifdef JOY2QUAD_POS_EN
                    step = 1'b1;
`endif
                    phase_nx = (req == ST_CW) ? phase + 2'd1 : phase - 2'd1;
                    if (!accel_en) begin
                        cur_div_nx = SLOW_V;
                        div_cnt_nx = SLOW_V - DIV_W'(1);
                    end else if (ramp_cnt == RAMP_LAST) begin
                        ramp_cnt_nx = '0;
                        cur_div_nx  = ramped;
                        div_cnt_nx  = ramped - DIV_W'(1);
                    end else begin
                        ramp_cnt_nx = ramp_cnt + RW'(1);
                        div_cnt_nx  = cur_div - DIV_W'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                state    <= ST_IDLE;
                phase    <= 2'd0;
                steer_q  <= 2'b00;
                moving_q <= 1'b0;
                div_cnt  <= '0;
                cur_div  <= SLOW_V;
                ramp_cnt <= '0;
            end else begin
                state    <= state_nx;
                phase    <= phase_nx;
                steer_q  <= gray(phase_nx);
                moving_q <= (state_nx != ST_IDLE);
                div_cnt  <= div_cnt_nx;
                cur_div  <= cur_div_nx;
                ramp_cnt <= ramp_cnt_nx;
            end
        end

`ifdef JOY2QUAD_POS_EN
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                pos_q <= 8'sd0;
            end else if (step) begin
                if (state == ST_CW && pos_q != 8'sd127) begin
                    pos_q <= pos_q + 8'sd1;
                end else if (state == ST_CCW && pos_q != -8'sd128) begin
                    pos_q <= pos_q - 8'sd1;
                end
            end
        end
        assign pos[8*c +: 8] = pos_q;
`endif

        assign steer[2*c +: 2] = steer_q;
        assign moving[c]       = moving_q;
    end

endmodule

// File: tb/tb_joy2quad_multi.sv
// Bench for joy2quad_multi: cycle model of step timing and Gray output, plus directed literal checks.
// Define JOY2QUAD_POS_EN for both files to also exercise the position output.
module tb_joy2quad_multi;
    localparam int SLOW = 8, FAST = 2, DEC = 2, RAMP = 2;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       accel_en = 1'b0;
    logic [1:0] left = 2'b00;
    logic [1:0] right = 2'b00;
    logic [3:0] steer;
    logic [1:0] moving;
`ifdef JOY2QUAD_POS_EN
    logic [15:0] pos;
`endif

    joy2quad_multi #(
        .NUM_CH(2), .DIV_W(16), .SLOW_DIV(SLOW), .FAST_DIV(FAST), .DIV_DEC(DEC), .RAMP_STEPS(RAMP)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .left(left), .right(right), .accel_en(accel_en),
        .steer(steer), .moving(moving)
`ifdef JOY2QUAD_POS_EN
        , .pos(pos)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0, bad = 0, cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] gray(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // Model: runs restart on any change of request; step k (0-based) follows an interval of
    // max(FAST, SLOW - DEC*floor(k/RAMP)) when accelerating, else SLOW.
    int m_phase[2], m_k[2], m_rem[2], m_req[2], m_pos[2];
    bit m_mov[2], m_step[2];

    always @(posedge clk_sys) begin
        cyc++;
        for (int c = 0; c < 2; c++) begin
            int req, dir, iv;
            m_step[c] = 1'b0;
            req = (right[c] && !left[c]) ? 1 : (left[c] && !right[c]) ? 2 : 0;
            if (reset) begin
                m_phase[c] = 0; m_req[c] = 0; m_mov[c] = 0; m_pos[c] = 0; m_k[c] = 0; m_rem[c] = 0;
            end else if (req != m_req[c]) begin
                m_req[c] = req; m_k[c] = 0; m_rem[c] = SLOW; m_mov[c] = (req != 0);
            end else if (req != 0) begin
                m_rem[c]--;
                if (m_rem[c] == 0) begin
                    dir = (req == 1) ? 1 : -1;
                    m_step[c]  = 1'b1;
                    m_phase[c] = (m_phase[c] + dir + 4) % 4;
                    m_pos[c]   = m_pos[c] + dir;
                    if (m_pos[c] > 127) m_pos[c] = 127;
                    if (m_pos[c] < -128) m_pos[c] = -128;
                    m_k[c]++;
                    iv = SLOW - DEC * (m_k[c] / RAMP);
                    if (iv < FAST) iv = FAST;
                    m_rem[c] = accel_en ? iv : SLOW;
                end
            end
        end
    end

    logic [1:0] d_prev[2] = '{2'b00, 2'b00};

    always @(negedge clk_sys) begin
        if (cyc > 0) begin
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("ch%0d steer", c), 32'(steer[2*c +: 2]), 32'(gray(m_phase[c])));
                chk($sformatf("ch%0d moving", c), 32'(moving[c]), 32'(m_mov[c]));
                if (m_step[c])
                    chk($sformatf("ch%0d one-bit toggle", c),
                        32'($countones(steer[2*c +: 2] ^ d_prev[c])), 32'd1);
`ifdef JOY2QUAD_POS_EN
                chk($sformatf("ch%0d pos", c), 32'(int'($signed(pos[8*c +: 8]))), 32'(m_pos[c]));
`endif
                d_prev[c] = steer[2*c +: 2];
            end
        end
    end

    task automatic go(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wait_step(input int c, output int at);
        logic [1:0] p;
        p  = steer[2*c +: 2];
        at = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_sys);
            if (steer[2*c +: 2] !== p) begin
                at = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL ch%0d step wait: no step within 64 cycles, got none expected one", c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t0;
        logic [1:0] exp_fixed[4];
        int exp_int[9];
        exp_fixed = '{2'b01, 2'b11, 2'b10, 2'b00};
        exp_int   = '{8, 8, 6, 6, 4, 4, 2, 2, 2};

        // reset held with both rights pressed
        reset = 1'b1; right = 2'b11; accel_en = 1'b0;
        go(3);
        chk("reset steer", 32'(steer), 32'd0);
        chk("reset moving", 32'(moving), 32'd0);
        reset = 1'b0; t0 = cyc + 1;
        wait_step(0, t);
        chk("first step delay", 32'(t - t0), 32'd8);
        chk("first step steer", 32'(steer[1:0]), 32'b01);

        // fixed rate
        reset = 1'b1; right = 2'b00;
        go(1);
        reset = 1'b0; right = 2'b01; t0 = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            wait_step(0, t);
            chk("fixed interval", 32'(t - t0), 32'd8);
            chk("fixed steer", 32'(steer[1:0]), 32'(exp_fixed[i]));
            t0 = t;
        end
        chk("ch1 idle steer", 32'(steer[3:2]), 32'd0);

        // acceleration ramp
        right = 2'b00;
        go(3);
        accel_en = 1'b1; right = 2'b01; t0 = cyc + 1;
        for (int i = 0; i < 9; i++) begin
            wait_step(0, t);
            chk("ramp interval", 32'(t - t0), 32'(exp_int[i]));
            t0 = t;
        end
        chk("ramp end steer", 32'(steer[1:0]), 32'b01);

        // both pressed, then left
        left = 2'b11; right = 2'b11;
        go(20);
        chk("both steer held", 32'(steer[1:0]), 32'b01);
        chk("both moving", 32'(moving), 32'd0);
        left = 2'b01; right = 2'b00; t0 = cyc + 1;
        wait_step(0, t);
        chk("ccw interval 1", 32'(t - t0), 32'd8);
        chk("ccw steer 1", 32'(steer[1:0]), 32'b00);
        t0 = t;
        wait_step(0, t);
        chk("ccw interval 2", 32'(t - t0), 32'd8);
        chk("ccw steer 2", 32'(steer[1:0]), 32'b10);

        // direct reversal during the 4-cycle interval
        left = 2'b00; right = 2'b01;
        for (int i = 0; i < 4; i++) wait_step(0, t);
        go(2);
        chk("pre-reversal steer", 32'(steer[1:0]), 32'b10);
        left = 2'b01; right = 2'b00; t0 = cyc + 1;
        wait_step(0, t);
        chk("reversal interval", 32'(t - t0), 32'd8);
        chk("reversal steer", 32'(steer[1:0]), 32'b11);

        // reset between steps
        go(3);
        reset = 1'b1;
        go(1);
        chk("mid-run reset steer", 32'(steer[1:0]), 32'd0);
        chk("mid-run reset moving", 32'(moving), 32'd0);
        reset = 1'b0; left = 2'b00;
        go(2);

`ifdef JOY2QUAD_POS_EN
        right = 2'b01;
        for (int i = 0; i < 130; i++) wait_step(0, t);
        chk("pos saturated", 32'(int'($signed(pos[7:0]))), 32'd127);
        chk("steer after 130", 32'(steer[1:0]), 32'b11);
        wait_step(0, t);
        wait_step(0, t);
        chk("pos still saturated", 32'(int'($signed(pos[7:0]))), 32'd127);
        chk("steer wraps", 32'(steer[1:0]), 32'b00);
        right = 2'b00;
        go(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
